// File: rtl/systolic_mm_pkg.sv
// Shared types and helpers for the systolic_mm_engine output-stationary matrix multiplier.
package systolic_mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN
    } mm_state_e;

    // Widest signed product/accumulator the sign-extension helper supports.
    localparam int unsigned MAX_W = 64;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [MAX_W-1:0] sext_prod(input logic [MAX_W-1:0] p,
                                                   input int unsigned       pw);
        logic [MAX_W-1:0] hi_mask;
        hi_mask = ~((MAX_W'(1) << pw) - MAX_W'(1));
        return p[pw-1] ? (p | hi_mask) : (p & ~hi_mask);
    endfunction

endpackage

// File: rtl/systolic_mm_pe.sv
// Single multiply-accumulate cell: forwards a right and b down through one register each.
module systolic_mm_pe
    import systolic_mm_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [DW-1:0] b_in,
    output logic signed [DW-1:0] a_out,
    output logic signed [DW-1:0] b_out,
    output logic signed [AW-1:0] acc_out
);

    logic signed [DW-1:0]   a_q, b_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [2*DW-1:0] prod;
    logic        [AW-1:0]   prod_ext;

    assign prod     = (2*DW)'(a_in) * (2*DW)'(b_in);
    assign prod_ext = AW'(sext_prod(MAX_W'($unsigned(prod)), 2*DW));

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q <= a_in;
            b_q <= b_in;
            if (clear) acc_q <= '0;
            else       acc_q <= acc_q + $signed(prod_ext);
        end
    end

    assign a_out   = a_q;
    assign b_out   = b_q;
    assign acc_out = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary N x N systolic matrix-multiply engine with internal input skew and row drain.
// Optional macro SYSTOLIC_MM_RELU_EN clamps negative output lanes to zero.
module systolic_mm_engine
    import systolic_mm_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*DW-1:0] in_a,
    input  logic [N*DW-1:0] in_b,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [N*AW-1:0] out_data,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready
);

    localparam int unsigned CW = cnt_width(2*N - 2);
    localparam int unsigned RW = cnt_width(N - 1);

    mm_state_e       state_q;
    logic            in_ready_q, out_valid_q, out_last_q;
    logic [N*AW-1:0] out_data_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   r_q;

    logic            in_xfer, acc_clr;
    logic [RW-1:0]   row_idx;
    logic [N*AW-1:0] row_d;
    logic            last_d;

    logic signed [DW-1:0] a_edge [N];
    logic signed [DW-1:0] b_edge [N];
    logic signed [DW-1:0] a_fwd  [N][N];
    logic signed [DW-1:0] b_fwd  [N][N];
    logic signed [AW-1:0] acc    [N][N];

    assign in_xfer = in_valid & in_ready_q;
    assign acc_clr = (state_q == DRAIN) & out_valid_q & out_ready & out_last_q;

    // Lane i passes through i+1 registers; the first captures the beat or a zero bubble.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic signed [DW-1:0] a_sh_q [0:gi];
        logic signed [DW-1:0] b_sh_q [0:gi];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned s = 0; s <= gi; s++) begin
                    a_sh_q[s] <= '0;
                    b_sh_q[s] <= '0;
                end
            end else begin
                a_sh_q[0] <= in_xfer ? in_a[DW*gi +: DW] : '0;
                b_sh_q[0] <= in_xfer ? in_b[DW*gi +: DW] : '0;
                for (int unsigned s = 1; s <= gi; s++) begin
                    a_sh_q[s] <= a_sh_q[s-1];
                    b_sh_q[s] <= b_sh_q[s-1];
                end
            end
        end

        assign a_edge[gi] = a_sh_q[gi];
        assign b_edge[gi] = b_sh_q[gi];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [DW-1:0] a_src, b_src;

            if (gj == 0) begin : g_a_edge
                assign a_src = a_edge[gi];
            end else begin : g_a_int
                assign a_src = a_fwd[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign b_src = b_edge[gj];
            end else begin : g_b_int
                assign b_src = b_fwd[gi-1][gj];
            end

            systolic_mm_pe #(
                .DW(DW),
                .AW(AW)
            ) u_pe (
                .clk    (clk),
                .reset  (reset),
                .clear  (acc_clr),
                .a_in   (a_src),
                .b_in   (b_src),
                .a_out  (a_fwd[gi][gj]),
                .b_out  (b_fwd[gi][gj]),
                .acc_out(acc[gi][gj])
            );
        end
    end

    // Once a row is on the output, the mux already points at the next row so a transfer reloads with no bubble.
    always_comb begin
        logic signed [AW-1:0] lane_v;
        row_idx = r_q;
        if (out_valid_q && (r_q != RW'(N-1))) row_idx = r_q + RW'(1);
        last_d = (row_idx == RW'(N-1));
        row_d  = '0;
        lane_v = '0;
        for (int unsigned j = 0; j < N; j++) begin
            lane_v = acc[row_idx][j];
`ifdef SYSTOLIC_MM_RELU_EN
            if (lane_v[AW-1]) lane_v = '0;
`endif
            row_d[AW*j +: AW] = lane_v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            r_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        if (in_last) begin
                            state_q    <= FLUSH;
                            in_ready_q <= 1'b0;
                            cnt_q      <= '0;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer && in_last) begin
                        state_q    <= FLUSH;
                        in_ready_q <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                FLUSH: begin
                    if (cnt_q == CW'(2*N - 2)) begin
                        state_q <= DRAIN;
                        r_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= row_d;
                        out_last_q  <= last_d;
                    end else if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            r_q         <= '0;
                        end else begin
                            r_q        <= row_idx;
                            out_data_q <= row_d;
                            out_last_q <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed self-checking bench for systolic_mm_engine (N=4, DW=8, AW=16).
module tb_systolic_mm_engine;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;

    logic            clk, reset;
    logic [N*DW-1:0] in_a, in_b;
    logic            in_valid, in_last, in_ready;
    logic [N*AW-1:0] out_data;
    logic            out_valid, out_last, out_ready;

    int checks   = 0;
    int failures = 0;

    logic signed [AW-1:0] exp_c [N][N];
    int ga [6][N];
    int gb [6][N];

    systolic_mm_engine #(
        .N (N),
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
        logic [N*DW-1:0] r;
        r[DW*0 +: DW] = DW'(v0);
        r[DW*1 +: DW] = DW'(v1);
        r[DW*2 +: DW] = DW'(v2);
        r[DW*3 +: DW] = DW'(v3);
        return r;
    endfunction

    function automatic logic signed [AW-1:0] relu(input logic signed [AW-1:0] v);
`ifdef SYSTOLIC_MM_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [N*AW-1:0] exp_row(input int unsigned r);
        logic [N*AW-1:0] ev;
        for (int unsigned j = 0; j < N; j++) ev[AW*j +: AW] = relu(exp_c[r][j]);
        return ev;
    endfunction

    task automatic send_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input logic last);
        int unsigned w;
        w        = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        in_last  = last;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("beat_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_latency(input int unsigned exp_cycles);
        int unsigned cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("first_valid_latency", cyc, exp_cycles);
    endtask

    task automatic drain(input int unsigned stall, input int unsigned nrows, input bit garbage);
        logic [N*AW-1:0] ev;
        int unsigned     w;
        for (int unsigned r = 0; r < nrows; r++) begin
            w = 0;
            while (out_valid !== 1'b1 && w < 64) begin
                @(posedge clk); #1;
                w++;
            end
            chk("row_valid", out_valid, 1'b1);
            ev = exp_row(r);
            for (int unsigned s = 0; s < stall; s++) begin
                out_ready = 1'b0;
                chk("stall_data", out_data, ev);
                chk("stall_valid", out_valid, 1'b1);
                @(posedge clk); #1;
            end
            chk("row_data", out_data, ev);
            chk("row_last", out_last, (r == N-1));
            if (garbage) begin
                chk("ready_low_drain", in_ready, 1'b0);
                if (r == N-1) begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        if (nrows == N) begin
            chk("idle_valid", out_valid, 1'b0);
            chk("idle_ready", in_ready, 1'b1);
        end
    endtask

    task automatic identity_job(input int base, input int scale);
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++)
                exp_c[i][j] = AW'(scale * (int'(4*i + j) + base));
        for (int unsigned k = 0; k < N; k++)
            send_beat(pack4(int'(k == 0), int'(k == 1), int'(k == 2), int'(k == 3)),
                      pack4(int'(exp_c[k][0]), int'(exp_c[k][1]),
                            int'(exp_c[k][2]), int'(exp_c[k][3])),
                      k == N-1);
    endtask

    initial begin
        reset     = 1'b1;
        in_a      = '0;
        in_b      = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_out_data", out_data, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", in_ready, 1'b1);

        // Identity: C must equal B, 2N-cycle first-row latency
        identity_job(1, 1);
        check_latency(8);
        drain(0, N, 1'b0);

        // K=1 outer product
        begin
            int av [N];
            int bv [N];
            av = '{1, 2, 3, 4};
            bv = '{-1, 2, -3, 4};
            for (int unsigned i = 0; i < N; i++)
                for (int unsigned j = 0; j < N; j++)
                    exp_c[i][j] = AW'(av[i] * bv[j]);
            send_beat(pack4(1, 2, 3, 4), pack4(-1, 2, -3, 4), 1'b1);
            check_latency(8);
            drain(0, N, 1'b0);
        end

        // K=6 with input gaps, then in_valid held high while blocked
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < int'(N); i++) begin
                ga[k][i] = ((k*3 + i*5) % 7) - 3;
                gb[k][i] = ((k*2 + i*3) % 9) - 4;
            end
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 6; k++) s += ga[k][i] * gb[k][j];
                exp_c[i][j] = AW'(s);
            end
        for (int k = 0; k < 6; k++) begin
            repeat (k % 3) @(posedge clk);
            #1;
            send_beat(pack4(ga[k][0], ga[k][1], ga[k][2], ga[k][3]),
                      pack4(gb[k][0], gb[k][1], gb[k][2], gb[k][3]), k == 5);
        end
        in_a     = pack4(7, 7, 7, 7);
        in_b     = pack4(7, 7, 7, 7);
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("ready_low_flush", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        drain(0, N, 1'b1);

        // Backpressure: two stall cycles per row, fresh job after the previous one
        identity_job(-9, 2);
        drain(2, N, 1'b0);

        // Overflow: 3 x (-128 * -128) = 49152 wraps to -16384 in 16 bits
        for (int unsigned i = 0; i < N; i++)
            for (int unsigned j = 0; j < N; j++)
                exp_c[i][j] = -16'sd16384;
        for (int k = 0; k < 3; k++)
            send_beat(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), k == 2);
        drain(0, N, 1'b0);

        // Reset after row 1 transfers
        identity_job(3, 1);
        drain(0, 2, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_out_valid", out_valid, 1'b0);
        chk("midreset_in_ready", in_ready, 1'b0);
        chk("midreset_out_data", out_data, '0);
        chk("midreset_out_last", out_last, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_midreset", in_ready, 1'b1);
        identity_job(1, 1);
        check_latency(8);
        drain(0, N, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
